// File: rtl/ltl_monitor_pkg.sv
// Shared constants and event record type for the LTL monitor report path.
// Default widths match a standard 4-report cluster automaton.
package ltl_monitor_pkg;

  localparam int unsigned LTL_NUM_REPORTS = 4;
  localparam int unsigned LTL_TS_WIDTH    = 32;

  typedef struct packed {
    logic [LTL_TS_WIDTH-1:0]    ts;
    logic [LTL_NUM_REPORTS-1:0] reports;
  } report_event_t;

  // Pointer width for a FIFO of the given depth; a depth of 1 still needs one bit.
  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ltl_report_collector_if.sv
// Valid/ready channel carrying timestamped report events to the aggregation logic.
interface ltl_report_collector_if
  import ltl_monitor_pkg::*;
#(
  parameter int unsigned NUM_REPORTS = LTL_NUM_REPORTS,
  parameter int unsigned TS_WIDTH    = LTL_TS_WIDTH
);

  logic                   out_valid;
  logic                   out_ready;
  logic [TS_WIDTH-1:0]    out_ts;
  logic [NUM_REPORTS-1:0] out_reports;

  modport master (
    output out_valid,
    output out_ts,
    output out_reports,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_ts,
    input  out_reports,
    output out_ready
  );

endinterface

// File: rtl/ltl_report_fifo.sv
// Generic synchronous FIFO with separate occupancy counter, async reset and sync clear.
// A push while full is accepted only when a pop happens in the same cycle.
module ltl_report_fifo
  import ltl_monitor_pkg::*;
#(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = ptr_width(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & (~full | do_pop) & ~clear;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PTR_W'(1);
      if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: nothing is read out until the count says it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/ltl_report_collector.sv
// Timestamps cycles with active automaton reports and queues them for the aggregator,
// tracking dropped events when the queue is full.
module ltl_report_collector
  import ltl_monitor_pkg::*;
#(
  parameter int unsigned NUM_REPORTS = LTL_NUM_REPORTS,
  parameter int unsigned TS_WIDTH    = LTL_TS_WIDTH,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DROP_WIDTH  = 16,
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   run,
  input  logic                   clear,
  input  logic [NUM_REPORTS-1:0] report_i,
  ltl_report_collector_if.master out,
  output logic [CNT_W-1:0]       fifo_count,
  output logic                   overflow,
  output logic [DROP_WIDTH-1:0]  drop_count,
  output logic [TS_WIDTH-1:0]    symbol_count
);

  typedef struct packed {
    logic [TS_WIDTH-1:0]    ts;
    logic [NUM_REPORTS-1:0] reports;
  } event_t;

  localparam int unsigned EVENT_W = $bits(event_t);

  logic [TS_WIDTH-1:0]   symbol_q, symbol_d;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;
  logic                  overflow_q, overflow_d;

  logic   event_hit, pop, drop, full, empty;
  event_t wr_event, head;

  assign event_hit = run & (|report_i);
  assign pop       = ~empty & out.out_ready;
  assign drop      = event_hit & full & ~pop & ~clear;

  // The event carries the index of the symbol that produced it, i.e. the pre-increment count.
  assign wr_event.ts      = symbol_q;
  assign wr_event.reports = report_i;

  ltl_report_fifo #(
    .WIDTH (EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (event_hit),
    .wdata   (wr_event),
    .pop     (pop),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  always_comb begin
    symbol_d   = symbol_q;
    drop_d     = drop_q;
    overflow_d = overflow_q;
    if (clear) begin
      symbol_d   = '0;
      drop_d     = '0;
      overflow_d = 1'b0;
    end else begin
      if (run) symbol_d = symbol_q + TS_WIDTH'(1);
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + DROP_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      symbol_q   <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      symbol_q   <= symbol_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
    end
  end

  // Head fields are masked while empty so stale storage never leaks onto the bus.
  assign out.out_valid   = ~empty;
  assign out.out_ts      = empty ? '0 : head.ts;
  assign out.out_reports = empty ? '0 : head.reports;

  assign overflow     = overflow_q;
  assign drop_count   = drop_q;
  assign symbol_count = symbol_q;

endmodule

// File: doc/ltl_report_collector.md
Name: ltl_report_collector

Overview:
- Sits directly downstream of the LTL monitor automata in each cluster.
- Consumes the automaton's report-state vector (e.g. the 4 report outputs of a cluster automaton), counts symbols while `run` is high, and timestamps every cycle with at least one active report.
- Buffers these report events in a small FIFO and hands them to the monitor aggregation logic over a valid/ready interface.
- Keeps sticky overflow status and a dropped-event count.

Parameters:
- NUM_REPORTS, 4, width of the report vector (one bit per report STE).
- TS_WIDTH, 32, width of the symbol counter / timestamp.
- FIFO_DEPTH, 8, number of buffered events; must be a power of 2, ≥2.
- DROP_WIDTH, 16, width of the dropped-event counter.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- run  in  1  symbol-valid qualifier, same signal that drives the automaton `run`.
- clear  in  1  synchronous flush of FIFO, counters and status.
- report_i  in  NUM_REPORTS  automaton report outputs, bit k = report STE k.
- out_valid  out  1  head event available.
- out_ready  in  1  consumer accepts head event.
- out_ts  out  TS_WIDTH  symbol index of head event.
- out_reports  out  NUM_REPORTS  report vector of head event.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: an event was dropped since reset/clear.
- drop_count  out  DROP_WIDTH  dropped events, saturating.
- symbol_count  out  TS_WIDTH  running symbol counter.

Behaviour:
- Reset values (asynchronous, reset_n=0):
  - out_valid=0, fifo_count=0, overflow=0, drop_count=0, symbol_count=0.
  - out_ts and out_reports are 0.
  - All FIFO pointers are 0.
- Symbol counter:
  - +1 each cycle with run=1; holds when run=0.
  - Wraps modulo 2^TS_WIDTH; no flag on wrap.
- Capture:
  - Event when run=1 and report_i≠0.
  - Entry = {symbol_count value before this cycle's increment, report_i}.
  - The first symbol after reset therefore has ts=0.
- Push/pop:
  - Push when an event occurs and (fifo_count<FIFO_DEPTH, or a pop happens in the same cycle).
  - Pop = out_valid & out_ready.
  - Full + event + pop in the same cycle: both occur, occupancy unchanged, no drop.
- Drop:
  - Event while full with no pop: the entry is discarded.
  - overflow is set to 1; drop_count increments and saturates at 2^DROP_WIDTH−1.
- Output:
  - out_valid = (fifo_count≠0); out_ts and out_reports show the head entry.
  - Latency: an event captured at posedge N is visible with out_valid=1 after posedge N (empty FIFO, no bypass). It can be popped at posedge N+1 at the earliest.
  - While out_valid=1 and out_ready=0, out_ts and out_reports hold stable.
  - out_ready while out_valid=0 is ignored.
- clear=1:
  - At the next posedge, empties the FIFO and zeroes symbol_count, drop_count and overflow.
  - Takes priority over a simultaneous push or pop; an event in the same cycle is neither captured nor counted as dropped.
- Pointer arithmetic:
  - Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - Occupancy is tracked in a separate counter, one bit wider than the pointers.
- Reset mid-operation: all state returns to reset values immediately; in-flight entries are lost.
- run=0 with report_i≠0: ignored, no capture, no drop.

Decomposition:
- Package ltl_monitor_pkg holds:
  - Default constants LTL_NUM_REPORTS=4 and LTL_TS_WIDTH=32.
  - Parameterized struct report_event_t {ts, reports}, built with defaults.
- Sub-module ltl_report_fifo:
  - Generic synchronous FIFO with push, pop, full, empty and count.
  - Async active-low reset and sync clear.
  - The collector instantiates it and adds capture, timestamp and drop logic.

Test Plan:
- Reset, then run=1 for 5 cycles with report_i=0, then report_i=4'b0100 for one cycle → one event with out_ts=5 and out_reports=4'b0100; out_valid rises the cycle after capture; symbol_count=6 afterwards.
- out_ready=0, 8 consecutive events with report_i=4'b0001 at ts 0..7, then 3 more → fifo_count=8, overflow=1, drop_count=3; draining then yields ts 0..7 in order.
- Full FIFO, out_ready=1 and an event in the same cycle (ts=20) → fifo_count stays 8, drop_count unchanged, ts=20 is the last entry drained.
- Alternate run 1/0 with report_i=4'b1000 held constant for 6 cycles → exactly 3 events with ts 0,1,2; symbol_count=3.
- With 4 entries queued, drop_count=2 and symbol_count=50, assert clear together with an event → next cycle fifo_count=0, out_valid=0, overflow=0, drop_count=0, symbol_count=0.
- Force drop_count to 2^DROP_WIDTH−1 via repeated overflow (DROP_WIDTH=2: 5 drops) → drop_count saturates at 3; assert reset_n=0 mid-stream → all outputs 0 asynchronously.
